// File: rtl/wide_mul_seq.sv
// Sequential LEN x LEN unsigned multiplier: one LEN x DW partial product per cycle,
// accumulated into a 2*LEN-bit sum that feeds the downstream Montgomery reduction.
module wide_mul_seq #(
    parameter int unsigned LEN = 256,
    parameter int unsigned DW  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN-1:0]     a,
    input  logic [LEN-1:0]     b,
    output logic               busy,
    output logic               done,
    output logic [2*LEN-1:0]   x
);

    localparam int unsigned ND = LEN / DW;
    localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;
    localparam int unsigned XW = 2 * LEN;
    localparam int unsigned PW = LEN + DW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [LEN-1:0] a_q, a_d;
    logic [LEN-1:0] b_q, b_d;
    logic [XW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [XW-1:0]  x_q, x_d;

    logic [DW-1:0]  digit;
    logic [PW-1:0]  pp;
    logic [XW-1:0]  acc_sum;

    // Next-state, datapath and accept logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;

        digit   = b_q[32'(cnt_q) * DW +: DW];
        pp      = PW'(a_q) * PW'(digit);
        acc_sum = acc_q + (XW'(pp) << (32'(cnt_q) * DW));

        case (state_q)
            S_MUL: begin
                acc_d = acc_sum;
                if (cnt_q == CW'(ND - 1)) begin
                    x_d     = acc_sum;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A new request is only taken when no multiply is in flight
        if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

    assign busy = (state_q == S_MUL);
    assign done = (state_q == S_DONE);
    assign x    = x_q;

endmodule

// File: tb/tb_wide_mul_seq.sv
// Directed and random checks for wide_mul_seq, including latency, back-to-back
// operation, mid-operation reset and a Montgomery-reduction consistency check on x.
module tb_wide_mul_seq;

    localparam int unsigned LEN = 256;
    localparam int unsigned DW  = 32;
    localparam int unsigned ND  = LEN / DW;

    localparam logic [255:0] N_MOD     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] R_MOD_N   = 256'h1_000003D1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN-1:0]   a;
    logic [LEN-1:0]   b;
    logic             busy;
    logic             done;
    logic [2*LEN-1:0] x;

    int n_checks = 0;
    int n_errors = 0;

    wide_mul_seq #(.LEN(LEN), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .x     (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // x * 2^-256 mod N_MOD by repeated halving
    function automatic logic [255:0] redc(input logic [511:0] t);
        logic [513:0] v;
        v = 514'(t);
        for (int i = 0; i < 256; i++) begin
            if (v[0]) v = v + 514'(N_MOD);
            v = v >> 1;
        end
        if (v >= 514'(N_MOD)) v = v - 514'(N_MOD);
        return 256'(v);
    endfunction

    // One complete multiply from IDLE, checking latency, busy width, x stability and result
    task automatic run_mul(input string tag, input logic [255:0] ia, input logic [255:0] ib,
                           input logic [511:0] exp);
        int n;
        int nb;
        logic hold_ok;
        logic [511:0] x0;
        a     = ia;
        b     = ib;
        start = 1'b1;
        x0    = x;
        tick();
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        n = 0; nb = 0; hold_ok = 1'b1;
        while (!done && n < 20) begin
            if (busy) nb++;
            if (x !== x0) hold_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, "_latency"}, 512'(n), 512'(ND));
        check({tag, "_busy_cycles"}, 512'(nb), 512'(ND));
        check({tag, "_x_hold"}, 512'(hold_ok), 512'(1));
        check({tag, "_x"}, x, exp);
        tick();
        check({tag, "_done_one_cycle"}, 512'(done), 512'(0));
    endtask

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        logic [511:0] e;
        logic [511:0] lhs;
        logic [511:0] rhs;
        int n;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #23;
        check("reset_busy", 512'(busy), 512'(0));
        check("reset_done", 512'(done), 512'(0));
        check("reset_x", x, 512'(0));
        @(negedge clk);
        rst = 1'b0;

        run_mul("one", 256'd1, 256'd1, 512'd1);
        e = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
        run_mul("max", {256{1'b1}}, {256{1'b1}}, e);
        run_mul("zero_a", 256'd0, 256'hDEAD_BEEF_0123_4567, 512'd0);
        e = 512'd1 << 256;
        run_mul("pow255x2", 256'd1 << 255, 256'd2, e);
        e = 512'hFFFF_FFFF << 224;
        run_mul("top_digit", 256'hFFFF_FFFF, 256'd1 << 224, e);
        e = (512'd1 << 257) - 512'd2;
        run_mul("max_x2", {256{1'b1}}, 256'd2, e);
        run_mul("small", 256'd12345, 256'd6789, 512'd83810205);

        // start held high: operands change during MUL, re-accept in DONE
        a = 256'd3; b = 256'd5; start = 1'b1;
        tick();
        a = 256'd7;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("b2b_first_latency", 512'(n), 512'(ND));
        check("b2b_first_x", x, 512'd15);
        tick();
        check("b2b_reaccept_busy", 512'(busy), 512'(1));
        n = 1;
        while (!done && n < 20) begin tick(); n++; end
        check("b2b_interval", 512'(n), 512'(ND + 1));
        check("b2b_second_x", x, 512'd35);
        start = 1'b0;
        tick();
        check("b2b_idle_done", 512'(done), 512'(0));
        check("b2b_idle_busy", 512'(busy), 512'(0));

        // reset in the 4th MUL cycle abandons the operation
        a = 256'd9; b = 256'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mid_busy_before_rst", 512'(busy), 512'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_x", x, 512'(0));
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) n++;
        end
        check("rst_no_later_done", 512'(n), 512'(0));
        run_mul("after_rst", 256'd11, 256'd13, 512'd143);

        // random pairs against the reference product, plus reduction-stage consistency
        for (int k = 0; k < 1000; k++) begin
            for (int j = 0; j < 8; j++) begin
                ra[j*32 +: 32] = $urandom();
                rb[j*32 +: 32] = $urandom();
            end
            e = 512'(ra) * 512'(rb);
            run_mul("rand", ra, rb, e);
            if (k < 4) begin
                lhs = (512'(redc(x)) * 512'(R_MOD_N)) % 512'(N_MOD);
                rhs = ((512'(ra) % 512'(N_MOD)) * (512'(rb) % 512'(N_MOD))) % 512'(N_MOD);
                check("redc_consistency", lhs, rhs);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
